pulse_cmd_buf: RTL and testbench
================================

// Module: pulse_cmd_buf
// PURPOSE
//  Elastic buffer between the processor core's pulse command output and the downstream pulse/element
//  consumer. Captures the 72-bit pulse command on every core strobe (cmd_out/cstrobe_out), queues it in a
//  small FIFO and hands it off over a valid/ready handshake, so a stalled consumer never loses a
//  timed pulse silently. Drops on overflow are flagged and counted.
// PARAMETERS
//  CMD_WIDTH   72  width of one pulse command word
//  DEPTH       4   FIFO entries; power of 2, >= 2
//  ADDR_WIDTH  2   log2(DEPTH)
//  DROP_WIDTH  8   width of saturating drop counter
// PORTS
//  clk          in   1             single clock domain
//  reset        in   1             asynchronous, active-low (0 = reset)
//  cmd_in       in   CMD_WIDTH     pulse command from core, sampled only when cstrobe_in=1
//  cstrobe_in   in   1             push request, 1-cycle pulses from core
//  flush        in   1             synchronous clear of contents (stats kept)
//  stat_clr     in   1             synchronous clear of overflow and drop_cnt
//  cmd_out      out  CMD_WIDTH     head entry; valid only while cmd_valid=1
//  cmd_valid    out  1             head entry available
//  cmd_ready    in   1             consumer accepts head when cmd_valid & cmd_ready
//  count        out  ADDR_WIDTH+1  occupied entries, 0..DEPTH
//  full         out  1             count == DEPTH
//  overflow     out  1             sticky: a push was dropped
//  drop_cnt     out  DROP_WIDTH    dropped pushes, saturates at all-ones
// BEHAVIOUR
//  - Reset (reset=0, any time, async assert, sync deassert): rd_ptr=wr_ptr=0, count=0, cmd_valid=0,
//    full=0, overflow=0, drop_cnt=0, cmd_out=0. Contents lost; no pop/push completes in reset.
//  - Storage: DEPTH x CMD_WIDTH flop array; wr_ptr/rd_ptr ADDR_WIDTH bits, natural wrap DEPTH-1 -> 0.
//  - push = cstrobe_in; pop = cmd_valid & cmd_ready. All state updates on rising clk.
//  - cmd_valid = (count != 0), registered. cmd_out = mem[rd_ptr], registered.
//    Latency: strobe in cycle N into empty buffer -> cmd_valid=1 and cmd_out=cmd_in in cycle N+1
//    (write-through into output register when empty, or when count==1 and pop).
//  - Pop: rd_ptr+1, count-1; cmd_out updates to next entry in the same edge; cmd_valid drops the edge
//    after the last entry is popped unless a push occurs in the same cycle.
//  - Push & pop same cycle: both succeed at any occupancy incl. full and empty-with-write-through;
//    count unchanged (except empty: push only since pop impossible, cmd_valid=0).
//  - Push when full and no pop: command dropped (FIFO unchanged), overflow<=1, drop_cnt+1 saturating.
//  - cmd_out/cmd_valid must hold stable while cmd_valid & !cmd_ready (AXI-style rule).
//  - flush=1: pointers, count, cmd_valid cleared next edge; a push in the flush cycle is discarded
//    (not counted as drop); a pop in the flush cycle is still reported to the consumer but the
//    entry is gone. flush has priority over push/pop.
//  - stat_clr=1: overflow<=0, drop_cnt<=0; if a drop occurs in the same cycle, set wins
//    (overflow=1, drop_cnt=1).
//  - cmd_ready is ignored while cmd_valid=0.
//  - No combinational path from cmd_ready or cstrobe_in to any output.
// TESTING
//  1. Reset then single strobe cmd_in=72'hA5_0000_0001_2345_6789, cmd_ready=1 -> cmd_valid=1 one
//     cycle later with that value, pop next edge, count returns 0, cmd_valid=0.
//  2. cmd_ready=0, 4 strobes (values 1..4) -> count=4, full=1, cmd_out=1; 5th strobe value 5 ->
//     overflow=1, drop_cnt=1; then cmd_ready=1 drains 1,2,3,4 in order, 5 never appears.
//  3. full, strobe and pop in same cycle (value 9) -> count stays 4, no drop; drain order 2,3,4,9.
//  4. wrap: 10 push/pop pairs with DEPTH=4 at occupancy 1..3 -> output order equals input order,
//     pointers wrap without loss.
//  5. 300 strobes while cmd_ready=0 and full -> drop_cnt=8'hFF (saturated); stat_clr -> 0, overflow=0.
//  6. reset=0 asserted mid-drain with count=3 -> outputs cleared asynchronously, no further pops;
//     flush with count=2 plus simultaneous strobe -> count=0, drop_cnt unchanged.

Source files
------------

// File: rtl/pulse_cmd_buf_if.sv
// Handshake bundle between core pulse-command output, the elastic buffer and the consumer.
// Push side: cmd_in/cstrobe_in from the core. Pop side: cmd_out/cmd_valid/cmd_ready.
// master = core+consumer view, slave = buffer view.
interface pulse_cmd_buf_if #(
  parameter int CMD_WIDTH = 72
);
  logic [CMD_WIDTH-1:0] cmd_in;
  logic                 cstrobe_in;
  logic [CMD_WIDTH-1:0] cmd_out;
  logic                 cmd_valid;
  logic                 cmd_ready;

  modport master (
    output cmd_in, cstrobe_in, cmd_ready,
    input  cmd_out, cmd_valid
  );

  modport slave (
    input  cmd_in, cstrobe_in, cmd_ready,
    output cmd_out, cmd_valid
  );
endinterface

// File: rtl/pulse_cmd_buf.sv
// Elastic FIFO for core pulse commands; drops on overflow are flagged and counted.
// Latency: strobe in cycle N into an empty buffer -> cmd_valid/cmd_out in cycle N+1.
// Backpressure: cmd_ready low holds the head stable; pushes into a full buffer without a pop are dropped.
module pulse_cmd_buf #(
  parameter int CMD_WIDTH  = 72,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int DROP_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  stat_clr_i,
  pulse_cmd_buf_if.slave        bus,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  overflow_o,
  output logic [DROP_WIDTH-1:0] drop_cnt_o
);

  logic [CMD_WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  valid_q, valid_d;
  logic [CMD_WIDTH-1:0]  out_q, out_d;
  logic                  ovf_q, ovf_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;

  logic push, pop, is_full, do_push, drop;

  assign push    = bus.cstrobe_in;
  assign pop     = valid_q & bus.cmd_ready;
  assign is_full = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push & ~flush_i & (~is_full | pop);
  assign drop    = push & ~flush_i & is_full & ~pop;

  // Next-state for pointers, occupancy, output register and drop statistics.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    out_d    = out_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{ADDR_WIDTH{1'b0}}, do_push} - {{ADDR_WIDTH{1'b0}}, pop};
      valid_d = (count_d != '0);
      // New head is the incoming word when it lands exactly at the new read slot (write-through).
      if (do_push && (wr_ptr_q == rd_ptr_d)) out_d = bus.cmd_in;
      else                                   out_d = mem_q[rd_ptr_d];
    end

    // A drop in the clear cycle wins: it is the first drop of the fresh statistics window.
    if (drop) begin
      ovf_d  = 1'b1;
      if (stat_clr_i)         drop_d = {{(DROP_WIDTH-1){1'b0}}, 1'b1};
      else if (drop_q != '1)  drop_d = drop_q + 1'b1;
    end else if (stat_clr_i) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // Storage array, written at the write pointer on an accepted push.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= bus.cmd_in;
    end
  end

  assign bus.cmd_out   = out_q;
  assign bus.cmd_valid = valid_q;
  assign count_o       = count_q;
  assign full_o        = is_full;
  assign overflow_o    = ovf_q;
  assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_pulse_cmd_buf.sv
module tb_pulse_cmd_buf;
  localparam int W = 72;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush, stat_clr;
  logic [2:0] count;
  logic       full, overflow;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a queue of pending commands plus drop statistics.
  logic [W-1:0] mq[$];
  bit           m_ovf;
  int           m_drop;

  pulse_cmd_buf_if #(.CMD_WIDTH(W)) bus ();

  pulse_cmd_buf #(.CMD_WIDTH(W), .DEPTH(4), .ADDR_WIDTH(2), .DROP_WIDTH(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .stat_clr_i (stat_clr),
    .bus        (bus.slave),
    .count_o    (count),
    .full_o     (full),
    .overflow_o (overflow),
    .drop_cnt_o (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid", W'(bus.cmd_valid), W'(mq.size() != 0));
    if (mq.size() != 0) chk("cmd_out", bus.cmd_out, mq[0]);
    chk("count", W'(count), W'(mq.size()));
    chk("full", W'(full), W'(mq.size() == 4));
    chk("overflow", W'(overflow), W'(m_ovf));
    chk("drop_cnt", W'(drop_cnt), W'(m_drop));
  endtask

  function automatic void model_step(logic [W-1:0] c, logic s, logic r, logic f, logic x);
    bit p, d;
    p = (mq.size() != 0) && r;
    d = 1'b0;
    if (f) begin
      mq.delete();
    end else begin
      d = s && (mq.size() == 4) && !p;
      if (p) void'(mq.pop_front());
      if (s && !d) mq.push_back(c);
    end
    if (d) begin
      m_ovf  = 1'b1;
      m_drop = x ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else if (x) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
  endfunction

  // Called at a negedge: drive inputs, advance model, check at the following negedge.
  task automatic step(input logic [W-1:0] c, input logic s, input logic r,
                      input logic f = 1'b0, input logic x = 1'b0);
    bus.cmd_in     = c;
    bus.cstrobe_in = s;
    bus.cmd_ready  = r;
    flush          = f;
    stat_clr       = x;
    model_step(c, s, r, f, x);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [W-1:0] rnd_cmd();
    return {$urandom, $urandom, 8'($urandom)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    chk("rst_cmd_out", bus.cmd_out, '0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.cmd_in = '0; bus.cstrobe_in = 0; bus.cmd_ready = 0;
    flush = 0; stat_clr = 0; rst_n = 1'b1;
    @(negedge clk);
    do_reset();

    // 1: single command with write-through, then popped
    step(72'hA5_0000_0001_2345_6789, 1, 1);
    chk("t1_out", bus.cmd_out, 72'hA5_0000_0001_2345_6789);
    step('0, 0, 1);
    chk("t1_empty", W'(count), '0);

    // 2: fill to full, overflow one, drain in order
    for (int i = 1; i <= 4; i++) step(W'(i), 1, 0);
    chk("t2_full", W'(full), W'(1));
    step(W'(5), 1, 0);
    chk("t2_drop", W'(drop_cnt), W'(1));
    for (int i = 1; i <= 4; i++) begin
      chk("t2_order", bus.cmd_out, W'(i));
      step('0, 0, 1);
    end

    // 3: push and pop together while full
    for (int i = 1; i <= 4; i++) step(W'(i), 1, 0);
    step(W'(9), 1, 1);
    chk("t3_count", W'(count), W'(4));
    chk("t3_nodrop", W'(drop_cnt), W'(1));
    for (int i = 0; i < 4; i++) step('0, 0, 1);

    // 4: wrap with simultaneous push/pop at occupancy 1..3
    for (int occ = 1; occ <= 3; occ++) begin
      for (int i = 0; i < occ; i++) step(rnd_cmd(), 1, 0);
      for (int i = 0; i < 10; i++) step(rnd_cmd(), 1, 1);
      while (mq.size() != 0) step('0, 0, 1);
    end

    // 5: saturate drop counter, then clear statistics
    for (int i = 0; i < 4; i++) step(rnd_cmd(), 1, 0);
    for (int i = 0; i < 300; i++) step(rnd_cmd(), 1, 0);
    chk("t5_sat", W'(drop_cnt), W'(8'hFF));
    step('0, 0, 0, 0, 1);
    chk("t5_clr", W'(overflow), '0);
    step(rnd_cmd(), 1, 0, 0, 1);   // drop in the clear cycle wins
    chk("t5_setwins", W'(drop_cnt), W'(1));

    // 6: asynchronous reset mid-drain, then flush with concurrent strobe
    step('0, 0, 1);
    chk("t6_count3", W'(count), W'(3));
    #2;
    do_reset();
    step('0, 0, 1);
    for (int i = 0; i < 4; i++) step(rnd_cmd(), 1, 0);
    step(rnd_cmd(), 1, 0);
    for (int i = 0; i < 2; i++) step('0, 0, 1);
    step(rnd_cmd(), 1, 0, 1, 0);
    chk("t6_flush", W'(count), '0);
    chk("t6_dropkeep", W'(drop_cnt), W'(1));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int sp;
      sp = (i / 500) % 3;
      step(rnd_cmd(),
           ($urandom_range(0, 3) < (sp + 1)),
           ($urandom_range(0, 3) >= sp),
           ($urandom_range(0, 47) == 0),
           ($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
